// File: rtl/serial_add_pkg.sv
// Shared encodings for the bit-serial adder controller and its bench.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder shared by the serial controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller, LSB first, one bit per clock.
// Define SUBTRACT_EN to add the op_sub input (result = op_a - op_b).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SUBTRACT_EN
    input  logic             op_sub,
`endif
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic [WIDTH-1:0] res_sh_d;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    count_q;
    logic             carry_q;
    logic             cout_q;
    logic             start_ready_q;
    logic             result_valid_q;
    logic             busy_q;

    logic             sum_bit;
    logic             c_out;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             unused_res_lsb;

`ifdef SUBTRACT_EN
    assign b_in = op_sub ? ~op_b : op_b;
    assign c_in = op_sub ? 1'b1 : cin;
`else
    assign b_in = op_b;
    assign c_in = cin;
`endif

    full_adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (carry_q),
        .sum   (sum_bit),
        .carry (c_out)
    );

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_sh_d = sum_bit;
        end else begin : g_res_wn
            assign res_sh_d = {sum_bit, res_sh_q[WIDTH-1:1]};
        end
    endgenerate

    // The LSB of the partial-sum register shifts out once the last bit lands.
    assign unused_res_lsb = res_sh_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            a_sh_q         <= '0;
            b_sh_q         <= '0;
            res_sh_q       <= '0;
            result_q       <= '0;
            count_q        <= '0;
            carry_q        <= 1'b0;
            cout_q         <= 1'b0;
            start_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_valid && start_ready_q) begin
                        a_sh_q        <= op_a;
                        b_sh_q        <= b_in;
                        carry_q       <= c_in;
                        res_sh_q      <= '0;
                        count_q       <= '0;
                        state_q       <= ST_RUN;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                ST_RUN: begin
                    res_sh_q <= res_sh_d;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    carry_q  <= c_out;
                    count_q  <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q        <= ST_DONE;
                        result_q       <= res_sh_d;
                        cout_q         <= c_out;
                        result_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state_q        <= ST_IDLE;
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        start_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    result_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                    start_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign start_ready  = start_ready_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign cout         = cout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8.
// Vector table plus hand sequences for backpressure and mid-run reset.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             op_sub;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [WIDTH:0] sb_q[$];

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
        logic [WIDTH-1:0] er;
        logic             ec;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .cin          (cin),
`ifdef SUBTRACT_EN
        .op_sub       (op_sub),
`endif
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .cout         (cout),
        .busy         (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic s,
                          input logic [WIDTH-1:0] er, input logic ec);
        int n = 0;
        @(negedge clk);
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) chk("start_ready_timeout", 0, 1);
        op_a        = a;
        op_b        = b;
        cin         = c;
        op_sub      = s;
        start_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back({ec, er});
        #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int edges = 0;
        while (edges < 64) begin
            @(posedge clk);
            edges++;
            #1;
            if (result_valid) break;
        end
        chk("latency", edges, WIDTH);
    endtask

    task automatic handoff();
        logic [WIDTH:0] exp;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            exp = '0;
        end else begin
            exp = sb_q.pop_front();
        end
        chk("result", result, exp[WIDTH-1:0]);
        chk("cout", cout, exp[WIDTH]);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk("valid_after_handoff", result_valid, 0);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input logic s,
                         input logic [WIDTH-1:0] er, input logic ec);
        accept(a, b, c, s, er, ec);
        wait_valid();
        handoff();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic [WIDTH:0]   sum;

        rst_n        = 1'b0;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        op_a         = '0;
        op_b         = '0;
        cin          = 1'b0;
        op_sub       = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", start_ready, 1);
        rst_n = 1'b1;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
        for (int i = 0; i < 6; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, vecs[i].er, vecs[i].ec);

        for (int i = 0; i < 4; i++) begin
            ra  = WIDTH'($urandom_range(0, 255));
            rb  = WIDTH'($urandom_range(0, 255));
            rc  = 1'($urandom_range(0, 1));
            sum = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            do_op(ra, rb, rc, 1'b0, sum[WIDTH-1:0], sum[WIDTH]);
        end

        // Backpressure: hold DONE while new operands are offered.
        accept(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);
        wait_valid();
        @(negedge clk);
        op_a        = 8'h11;
        op_b        = 8'h22;
        cin         = 1'b0;
        start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_result", result, 8'h03);
            chk("bp_cout", cout, 0);
            chk("bp_start_ready", start_ready, 0);
            chk("bp_state", 32'(dut.state_q), 32'(ST_DONE));
        end
        handoff();
        chk("bp_idle_ready", start_ready, 1);
        @(posedge clk);
        sb_q.push_back({1'b0, 8'h33});
        #1;
        start_valid = 1'b0;
        chk("bp_accept_busy", busy, 1);
        wait_valid();
        handoff();

        // Reset in the 4th RUN cycle discards the operation.
        accept(8'hAB, 8'hCD, 1'b1, 1'b0, 8'h79, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb_q.pop_front());
        chk("abort_valid", result_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", start_ready, 1);
        chk("abort_result", result, 0);
        chk("abort_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0);

`ifdef SUBTRACT_EN
        do_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        do_op(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0);
        do_op(8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1);
`endif

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
